// File: rtl/codifica_hamming_serial_if.sv
// codifica_hamming_serial_if: word-in / codeword-out bundle for the Hamming(15,11) serial encoder.
// Ports: dado, erro_pos and in_valid travel to the encoder. in_ready, codigo,
// codigo_valid, tx_bit, tx_valid and tx_sof travel back to the source/receiver.
interface codifica_hamming_serial_if;
   logic [10:0] dado;
   logic [3:0]  erro_pos;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] codigo;
   logic        codigo_valid;
   logic        tx_bit;
   logic        tx_valid;
   logic        tx_sof;
   modport master (
      output dado, erro_pos, in_valid,
      input  in_ready, codigo, codigo_valid, tx_bit, tx_valid, tx_sof
   );
   modport slave (
      input  dado, erro_pos, in_valid,
      output in_ready, codigo, codigo_valid, tx_bit, tx_valid, tx_sof
   );
endinterface

// File: rtl/codifica_hamming_serial.sv
// codifica_hamming_serial: Hamming(15,11) encoder with optional single-bit error injection and LSB-first serial transmit.
// Ports: clk (rising edge), rst_n (async, active low), bus (slave modport):
//   dado/erro_pos/in_valid in, in_ready out; codigo/codigo_valid parallel codeword;
//   tx_bit/tx_valid/tx_sof serial stream, bit 0 first, tx_sof marks bit 0.
module codifica_hamming_serial #(
   parameter int INJ_EN = 1
) (
   input logic                           clk,
   input logic                           rst_n,
   codifica_hamming_serial_if.slave      bus
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [14:0] codigo_q;
   logic        codigo_valid_q;
   logic [14:0] enc;
   logic [14:0] mask;
   logic [14:0] enc_inj;
   logic        accept;
   // Data occupies the non-power-of-two positions; parity at positions 1, 2, 4, 8.
   always_comb begin
      enc = '0;
      enc[2] = bus.dado[0];
      enc[6:4] = bus.dado[3:1];
      enc[14:8] = bus.dado[10:4];
      enc[0] = ^{enc[2], enc[4], enc[6], enc[8], enc[10], enc[12], enc[14]};
      enc[1] = ^{enc[2], enc[5], enc[6], enc[9], enc[10], enc[13], enc[14]};
      enc[3] = ^{enc[4], enc[5], enc[6], enc[11], enc[12], enc[13], enc[14]};
      enc[7] = ^enc[14:8];
      mask = (INJ_EN != 0 && bus.erro_pos != 4'd0) ? (15'd1 << (bus.erro_pos - 4'd1)) : 15'd0;
      enc_inj = enc ^ mask;
   end
   // The last bit cycle also accepts, so frames can run back to back.
   assign bus.in_ready = (state_q == IDLE) || (cnt_q == 4'd14);
   assign accept = bus.in_valid && bus.in_ready;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      if (accept) begin
         state_d = SHIFT;
         cnt_d = 4'd0;
      end else if (state_q == SHIFT) begin
         state_d = (cnt_q == 4'd14) ? IDLE : SHIFT;
         cnt_d = (cnt_q == 4'd14) ? 4'd0 : cnt_q + 4'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= 4'd0;
         codigo_q <= '0;
         codigo_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         codigo_valid_q <= accept;
         if (accept) codigo_q <= enc_inj;
      end
   end
   // Serial outputs decode straight from state, so an async reset clears them at once.
   assign bus.codigo = codigo_q;
   assign bus.codigo_valid = codigo_valid_q;
   assign bus.tx_valid = (state_q == SHIFT);
   assign bus.tx_bit = (state_q == SHIFT) ? codigo_q[cnt_q] : 1'b0;
   assign bus.tx_sof = (state_q == SHIFT) && (cnt_q == 4'd0);
endmodule

// File: doc/codifica_hamming_serial.md
Name: codifica_hamming_serial

Overview:
- Hamming(15,11) encoder and serial transmitter; the transmit-side counterpart of corrige_hamming.
- Accepts 11-bit data words over a valid/ready handshake and builds the 15-bit codeword using the same bit layout corrige_hamming expects.
- Presents the codeword in parallel and shifts it out LSB-first on a one-bit serial line.
- An optional single-bit error-injection field lets benches exercise the receive-side corrector end-to-end.

Parameters:
- INJ_EN, 1, error injection enable (0: erro_pos is ignored and treated as 0).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- dado  input  11  data word to encode.
- erro_pos  input  4  injected-error position, sampled with dado: 0 = none; 1..15 flips codeword bit erro_pos-1.
- in_valid  input  1  dado/erro_pos valid.
- in_ready  output  1  block can accept a word this cycle.
- codigo  output  15  registered codeword being transmitted, after injection.
- codigo_valid  output  1  one-cycle pulse when codigo is loaded.
- tx_bit  output  1  serial data, codeword bit 0 first.
- tx_valid  output  1  tx_bit carries a codeword bit.
- tx_sof  output  1  high with codeword bit 0 of each frame.

Behaviour:
- Codeword bit mapping (index = position-1):
  - c[2]=dado[0], c[4]=dado[1], c[5]=dado[2], c[6]=dado[3], c[8]=dado[4] … c[14]=dado[10].
  - c[8..14] map dado[4..10] in ascending order.
- Parity bits:
  - c[0] = XOR of c[2],c[4],c[6],c[8],c[10],c[12],c[14].
  - c[1] = XOR of c[2],c[5],c[6],c[9],c[10],c[13],c[14].
  - c[3] = XOR of c[4],c[5],c[6],c[11],c[12],c[13],c[14].
  - c[7] = XOR of c[8] through c[14].
- Error injection: if INJ_EN=1 and erro_pos≠0, bit erro_pos-1 is inverted after the parity computation.
- Reset values (applied immediately on rst_n low): state IDLE, bit counter 0, codigo=0, codigo_valid=0, tx_bit=0, tx_valid=0, tx_sof=0.
- FSM states: IDLE and SHIFT.
- IDLE:
  - in_ready=1, tx_valid=0, tx_bit=0.
  - On in_valid at a clock edge, the encoded word is loaded into codigo and the shift register, the counter is set to 0, codigo_valid pulses, and the FSM moves to SHIFT.
- SHIFT:
  - tx_valid=1 and tx_bit=shift[count]. tx_sof=1 only when count=0.
  - count increments every cycle from 0 to 14.
- Latency: a word accepted at edge N drives bit 0 in the cycle after edge N. Bit k appears in cycle N+1+k.
- Frame end:
  - in_ready=1 during the count=14 cycle of SHIFT; no other SHIFT cycle asserts it.
  - If in_valid is high on that edge, the next word loads and SHIFT restarts at count 0 with no gap (back-to-back frames).
  - Otherwise the FSM returns to IDLE.
- in_valid when in_ready=0 is ignored. The source must hold dado/erro_pos until accepted.
- codigo holds its value until the next load. codigo_valid is high exactly one cycle per accepted word.
- Reset mid-frame: outputs go to reset values asynchronously and the frame is discarded. After release, the block restarts in IDLE.
- erro_pos values 1..15 are all legal. An injection at a parity position (1, 2, 4, 8) flips that parity bit.

Test Plan:
- Reset then dado=0x000, erro_pos=0 → codigo=0x0000; 15 serial bits all 0; tx_sof on the first bit; in_ready low during bits 0..13.
- dado=0x001 → codigo=0x0007; serial bits 1,1,1 then twelve 0s. dado=0x400 → codigo=0x408B.
- dado=0x7FF → codigo=0x7FFF. Then dado=0x000 held valid during bit 14 → next frame's bit 0 follows in the next cycle; tx_valid never drops between frames.
- dado=0x7FF, erro_pos=5, INJ_EN=1 → codigo=0x7FEF. Feeding codigo to corrige_hamming → saida=0x7FF. With INJ_EN=0 → codigo=0x7FFF.
- rst_n pulsed low at bit 7 → tx_valid, tx_bit, codigo, codigo_valid clear without waiting for a clock. After release, in_ready=1 and a new word transmits correctly.
- Random 1000 words with random erro_pos → corrige_hamming(codigo) equals dado for every frame. Serial reassembly of each frame equals codigo.
